// File: rtl/flit_credit_sender.sv
// flit_credit_sender
//   Upstream (writer) end of a per-VC input flit buffer link. Accepts flits
//   from the local output-port logic, enforces credit-based flow control per
//   virtual channel, drives the registered downstream buffer write interface,
//   and checks per-VC packet framing (header / body / tail).
//
// Ports
//   clk           in   1    rising-edge clock
//   reset         in   1    synchronous, active-low reset
//   flit_in       in   Fw   flit from local source (bit Fw-1 header, Fw-2 tail)
//   vc_sel        in   V    one-hot target VC of flit_in
//   flit_valid    in   1    flit_in / vc_sel valid
//   flit_ready    out  1    flit accepted when flit_valid & flit_ready
//   din           out  Fw   flit to downstream buffer (registered)
//   vc_num_wr     out  V    one-hot VC of din (registered)
//   wr_en         out  1    downstream write strobe (registered)
//   credit_in     in   V    credit return, one credit per set bit
//   vc_has_credit out  V    bit i: VC i credit count > 0
//   vc_pkt_active out  V    bit i: VC i is inside a packet
//   proto_err     out  1    sticky framing-violation / credit-overflow flag

module flit_credit_sender #(
    parameter int unsigned V  = 4,
    parameter int unsigned Fw = 32,
    parameter int unsigned B  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [Fw-1:0] flit_in,
    input  logic [V-1:0]  vc_sel,
    input  logic          flit_valid,
    output logic          flit_ready,
    output logic [Fw-1:0] din,
    output logic [V-1:0]  vc_num_wr,
    output logic          wr_en,
    input  logic [V-1:0]  credit_in,
    output logic [V-1:0]  vc_has_credit,
    output logic [V-1:0]  vc_pkt_active,
    output logic          proto_err
);

    localparam int unsigned CW = $clog2(B + 1);
    localparam logic [CW-1:0] B_CNT = CW'(B);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } vc_state_t;

    vc_state_t     state_q [V];
    vc_state_t     state_d [V];
    logic [CW-1:0] credit_q [V];

    logic          sel_onehot;
    logic          accept;
    logic          hdr;
    logic          tail;
    logic          sel_active;
    logic          drop;
    logic          write;
    logic [V-1:0]  dec;
    logic [V-1:0]  overflow;

    // ------------------------------------------------------------------
    // Handshake and framing decode for the selected VC
    // ------------------------------------------------------------------
    always_comb begin
        hdr        = flit_in[Fw-1];
        tail       = flit_in[Fw-2];
        sel_onehot = (vc_sel != '0) && ((vc_sel & (vc_sel - V'(1))) == '0);
        flit_ready = sel_onehot && ((vc_sel & vc_has_credit) != '0);
        accept     = flit_valid && flit_ready;
        // vc_sel is one-hot whenever accept is high, so this picks one state
        sel_active = (vc_sel & vc_pkt_active) != '0;
        // Framing violations still complete the handshake, but the flit is
        // dropped: no write and no credit consumed.
        drop       = accept && (sel_active ? hdr : !hdr);
        write      = accept && !drop;
        dec        = write ? vc_sel : '0;
    end

    // ------------------------------------------------------------------
    // Per-VC framing FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < V; i++) begin
            if (!reset) begin
                state_q[i] <= IDLE;
            end else begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-VC framing FSM: next state (advances only on accept)
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < V; i++) begin
            state_d[i] = state_q[i];
            if (accept && vc_sel[i]) begin
                case (state_q[i])
                    IDLE:    if (hdr && !tail) state_d[i] = ACTIVE;
                    ACTIVE:  if (!hdr && tail) state_d[i] = IDLE;
                    default: state_d[i] = IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-VC framing FSM and credit status outputs
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < V; i++) begin
            vc_pkt_active[i] = (state_q[i] == ACTIVE);
            vc_has_credit[i] = (credit_q[i] != '0);
        end
    end

    // ------------------------------------------------------------------
    // Credit counters
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < V; i++) begin
            overflow[i] = credit_in[i] && !dec[i] && (credit_q[i] == B_CNT);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < V; i++) begin
            if (!reset) begin
                credit_q[i] <= B_CNT;
            end else begin
                // Simultaneous return and consume cancel out; an overflowing
                // return saturates at B and is flagged via proto_err.
                case ({credit_in[i], dec[i]})
                    2'b10: if (credit_q[i] != B_CNT) credit_q[i] <= credit_q[i] + CW'(1);
                    2'b01: credit_q[i] <= credit_q[i] - CW'(1);
                    default: credit_q[i] <= credit_q[i];
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered downstream write interface and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            din       <= '0;
            vc_num_wr <= '0;
            wr_en     <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            wr_en <= write;
            if (write) begin
                din       <= flit_in;
                vc_num_wr <= vc_sel;
            end
            if (drop || (overflow != '0)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flit_credit_sender.sv
// tb_flit_credit_sender
//   Directed-vector bench for flit_credit_sender (V=4, Fw=32, B=4).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.

module tb_flit_credit_sender;

    localparam int unsigned V  = 4;
    localparam int unsigned Fw = 32;
    localparam int unsigned B  = 4;

    logic          clk;
    logic          reset;
    logic [Fw-1:0] flit_in;
    logic [V-1:0]  vc_sel;
    logic          flit_valid;
    logic          flit_ready;
    logic [Fw-1:0] din;
    logic [V-1:0]  vc_num_wr;
    logic          wr_en;
    logic [V-1:0]  credit_in;
    logic [V-1:0]  vc_has_credit;
    logic [V-1:0]  vc_pkt_active;
    logic          proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    flit_credit_sender #(.V(V), .Fw(Fw), .B(B)) dut (
        .clk           (clk),
        .reset         (reset),
        .flit_in       (flit_in),
        .vc_sel        (vc_sel),
        .flit_valid    (flit_valid),
        .flit_ready    (flit_ready),
        .din           (din),
        .vc_num_wr     (vc_num_wr),
        .wr_en         (wr_en),
        .credit_in     (credit_in),
        .vc_has_credit (vc_has_credit),
        .vc_pkt_active (vc_pkt_active),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [Fw-1:0] mk(input logic h, input logic t, input logic [29:0] p);
        return {h, t, p};
    endfunction

    task automatic do_reset();
        reset      = 1'b0;
        flit_valid = 1'b0;
        credit_in  = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Send n single-flit packets on VC vc; credit must run out exactly at the nth.
    task automatic drain_check(input int vc, input int n);
        logic [V-1:0] sel;
        logic [Fw-1:0] f;
        sel = '0;
        sel[vc] = 1'b1;
        for (int k = 0; k < n; k++) begin
            f = mk(1'b1, 1'b1, 30'(32'h100 + k));
            flit_in    = f;
            vc_sel     = sel;
            flit_valid = 1'b1;
            #1;
            check("drain_ready", 32'(flit_ready), 32'd1);
            tick();
            check("drain_wr_en", 32'(wr_en), 32'd1);
            check("drain_din", din, f);
            check("drain_credit", 32'(vc_has_credit[vc]), (k == n - 1) ? 32'd0 : 32'd1);
        end
        flit_valid = 1'b0;
        tick();
    endtask

    logic [Fw-1:0] f0, f1, f2, f3;

    initial begin
        reset      = 1'b0;
        flit_in    = '0;
        vc_sel     = '0;
        flit_valid = 1'b0;
        credit_in  = '0;

        // 1: reset state
        do_reset();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_din", din, 32'd0);
        check("rst_vc_num_wr", 32'(vc_num_wr), 32'd0);
        check("rst_has_credit", 32'(vc_has_credit), 32'hF);
        check("rst_pkt_active", 32'(vc_pkt_active), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);

        // 2: full packet on VC0 back-to-back, credits exhausted
        f0 = mk(1'b1, 1'b0, 30'h0AA);
        f1 = mk(1'b0, 1'b0, 30'h0B1);
        f2 = mk(1'b0, 1'b0, 30'h0B2);
        f3 = mk(1'b0, 1'b1, 30'h0CC);
        vc_sel = 4'b0001; flit_valid = 1'b1; flit_in = f0;
        #1;
        check("t2_ready", 32'(flit_ready), 32'd1);
        tick();
        check("t2_hdr_wr", 32'(wr_en), 32'd1);
        check("t2_hdr_din", din, f0);
        check("t2_vc", 32'(vc_num_wr), 32'h1);
        check("t2_active", 32'(vc_pkt_active), 32'h1);
        flit_in = f1; tick();
        check("t2_b1_wr", 32'(wr_en), 32'd1);
        check("t2_b1_din", din, f1);
        flit_in = f2; tick();
        check("t2_b2_wr", 32'(wr_en), 32'd1);
        check("t2_b2_din", din, f2);
        check("t2_credit_b2", 32'(vc_has_credit), 32'hF);
        flit_in = f3; tick();
        check("t2_tail_wr", 32'(wr_en), 32'd1);
        check("t2_tail_din", din, f3);
        check("t2_tail_vc", 32'(vc_num_wr), 32'h1);
        check("t2_credit0", 32'(vc_has_credit), 32'hE);
        check("t2_idle", 32'(vc_pkt_active), 32'h0);
        flit_in = mk(1'b1, 1'b1, 30'h0DD);
        #1;
        check("t2_ready_low", 32'(flit_ready), 32'd0);
        tick();
        check("t2_no_wr", 32'(wr_en), 32'd0);
        check("t2_din_hold", din, f3);
        flit_valid = 1'b0;
        vc_sel = 4'b0011;
        #1;
        check("t2_sel_not_onehot", 32'(flit_ready), 32'd0);
        vc_sel = 4'b0000;
        #1;
        check("t2_sel_zero", 32'(flit_ready), 32'd0);
        tick();

        // 3: credit return on VC1 while flit held
        drain_check(1, 4);
        f0 = mk(1'b1, 1'b1, 30'h111);
        flit_in = f0; vc_sel = 4'b0010; flit_valid = 1'b1;
        #1;
        check("t3_ready0", 32'(flit_ready), 32'd0);
        tick();
        check("t3_no_wr", 32'(wr_en), 32'd0);
        credit_in = 4'b0010;
        tick();
        credit_in = '0;
        #1;
        check("t3_ready_t1", 32'(flit_ready), 32'd1);
        check("t3_no_wr_t1", 32'(wr_en), 32'd0);
        tick();
        check("t3_wr_t2", 32'(wr_en), 32'd1);
        check("t3_din_t2", din, f0);
        check("t3_vc_t2", 32'(vc_num_wr), 32'h2);
        check("t3_credit1_0", 32'(vc_has_credit[1]), 32'd0);
        flit_valid = 1'b0;
        tick();
        // Simultaneous accept and credit on VC2 (count 3 -> stays 3)
        flit_in = mk(1'b1, 1'b1, 30'h222); vc_sel = 4'b0100; flit_valid = 1'b1;
        tick();
        credit_in = 4'b0100;
        tick();
        credit_in = '0; flit_valid = 1'b0;
        check("t3_simul_wr", 32'(wr_en), 32'd1);
        check("t3_simul_err", 32'(proto_err), 32'd0);
        tick();
        drain_check(2, 3);
        check("t3_no_err", 32'(proto_err), 32'd0);

        // 4: framing violations on VC3
        flit_in = mk(1'b0, 1'b0, 30'h333); vc_sel = 4'b1000; flit_valid = 1'b1;
        #1;
        check("t4_ready", 32'(flit_ready), 32'd1);
        tick();
        check("t4_drop_wr", 32'(wr_en), 32'd0);
        check("t4_err", 32'(proto_err), 32'd1);
        check("t4_idle", 32'(vc_pkt_active), 32'h0);
        check("t4_credit3", 32'(vc_has_credit[3]), 32'd1);
        f0 = mk(1'b1, 1'b0, 30'h344);
        flit_in = f0; tick();
        check("t4_hdr_wr", 32'(wr_en), 32'd1);
        check("t4_active", 32'(vc_pkt_active), 32'h8);
        flit_in = mk(1'b1, 1'b0, 30'h355); tick();
        check("t4_hdr2_drop", 32'(wr_en), 32'd0);
        check("t4_hdr2_din", din, f0);
        check("t4_still_active", 32'(vc_pkt_active), 32'h8);
        flit_in = mk(1'b0, 1'b1, 30'h366); tick();
        check("t4_tail_wr", 32'(wr_en), 32'd1);
        check("t4_tail_idle", 32'(vc_pkt_active), 32'h0);
        flit_valid = 1'b0; tick(); tick();
        check("t4_err_sticky", 32'(proto_err), 32'd1);

        // 5: credit overflow on VC0 at B
        do_reset();
        check("t5_err_clr", 32'(proto_err), 32'd0);
        credit_in = 4'b0001;
        tick();
        credit_in = '0;
        check("t5_err", 32'(proto_err), 32'd1);
        drain_check(0, 4);

        // 6: reset in the middle of a VC0 packet
        do_reset();
        flit_in = mk(1'b1, 1'b0, 30'h600); vc_sel = 4'b0001; flit_valid = 1'b1;
        tick();
        flit_in = mk(1'b0, 1'b0, 30'h601);
        tick();
        check("t6_active", 32'(vc_pkt_active), 32'h1);
        flit_in = mk(1'b0, 1'b0, 30'h602);
        reset = 1'b0;
        tick();
        check("t6_rst_wr", 32'(wr_en), 32'd0);
        check("t6_rst_active", 32'(vc_pkt_active), 32'h0);
        check("t6_rst_credit", 32'(vc_has_credit), 32'hF);
        check("t6_rst_din", din, 32'd0);
        flit_valid = 1'b0;
        tick();
        reset = 1'b1;
        drain_check(0, 4);
        check("t6_err", 32'(proto_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
